// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch requester
//   and the MEM-stage data requester. Only one transaction is in flight at a
//   time. The FSM walks IDLE -> ADDR -> DATA.
//
//   Data requests win by default. A starvation counter limits how many data
//   grants in a row can pass a waiting fetch.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   inst_*              fetch side:
//                         inst_req / inst_addr in;
//                         inst_addr_ok / inst_data_ok / inst_rdata out
//   data_*              MEM side:
//                         data_req / data_wr / data_size / data_addr /
//                         data_wdata in;
//                         data_addr_ok / data_data_ok / data_rdata out
//   req, wr, size,      shared-port request. wr, size, addr and wdata are
//   addr, wdata           held in registers for the whole transaction
//   addr_ok, data_ok,   shared-port handshakes and read data
//   rdata
//   memory_stall        MEM stage is waiting on memory (holds MEM/WB)
//   STARVE_MAX          most consecutive data grants while a fetch waits
module sram_like_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        memory_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      r_state;
    logic        r_owner_data;   // 1 = data side owns the port, 0 = fetch
    logic [2:0]  r_starve;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic [1:0]  r_size;

    logic        w_any_req;
    logic        w_pick_inst;
    logic        w_addr_hs;
    logic        w_data_hs;
    logic        w_idle;

    // Counter only moves up while a fetch is actually waiting; it saturates.
    function automatic logic [2:0] starve_next(input logic [2:0] cnt,
                                               input logic       fetch_waiting);
        if (!fetch_waiting)
            return 3'd0;
        else if (cnt >= STARVE_LIM)
            return STARVE_LIM;
        else
            return cnt + 3'd1;
    endfunction

    assign w_any_req   = inst_req | data_req;
    assign w_pick_inst = inst_req & (~data_req | (r_starve == STARVE_LIM));

    // Handshakes count only in their own state and never while in reset.
    // This keeps an abandoned transaction from forwarding a late data_ok.
    assign w_addr_hs = ~rst & (r_state == S_ADDR) & addr_ok;
    assign w_data_hs = ~rst & (r_state == S_DATA) & data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner_data <= 1'b0;
            r_starve     <= 3'd0;
            r_addr       <= 32'h0;
            r_wr         <= 1'b0;
            r_size       <= 2'd2;
            r_wdata      <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_ADDR;
                        if (w_pick_inst) begin
                            r_owner_data <= 1'b0;
                            r_addr       <= inst_addr;
                            r_wr         <= 1'b0;
                            r_size       <= 2'd2;
                            r_wdata      <= 32'h0;
                            r_starve     <= 3'd0;
                        end else begin
                            r_owner_data <= 1'b1;
                            r_addr       <= data_addr;
                            r_wr         <= data_wr;
                            r_size       <= data_size;
                            r_wdata      <= data_wdata;
                            r_starve     <= starve_next(r_starve, inst_req);
                        end
                    end
                end
                S_ADDR: begin
                    // addr_ok wins even if data_ok arrives in the same cycle.
                    if (addr_ok)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (data_ok)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req   = ~rst & (r_state == S_ADDR);
    assign wr    = r_wr;
    assign size  = r_size;
    assign addr  = r_addr;
    assign wdata = r_wdata;

    assign inst_addr_ok = w_addr_hs & ~r_owner_data;
    assign data_addr_ok = w_addr_hs &  r_owner_data;
    assign inst_data_ok = w_data_hs & ~r_owner_data;
    assign data_data_ok = w_data_hs &  r_owner_data;

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    // Reset counts as IDLE. The stall then follows data_req during reset.
    assign w_idle       = rst | (r_state == S_IDLE);
    assign memory_stall = (w_idle & data_req)
                        | (~w_idle & r_owner_data & ~((r_state == S_DATA) & data_ok));

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        memory_stall;

    sram_like_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .memory_stall(memory_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        own_data;
        logic [31:0] a;
        logic        w;
        logic [1:0]  s;
        logic [31:0] wd;
    } grant_t;

    typedef struct {
        logic        own_data;
        logic [31:0] rd;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a handshake.
    grant_t mg;
    done_t  md;
    always @(negedge clk) begin
        if (inst_addr_ok && data_addr_ok)
            chk("addr_ok_exclusive", 32'(inst_addr_ok & data_addr_ok), 32'h0);
        if (inst_data_ok && data_data_ok)
            chk("data_ok_exclusive", 32'(inst_data_ok & data_data_ok), 32'h0);
        if (inst_addr_ok || data_addr_ok) begin
            if (gq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_grant: got inst_addr_ok=%0b data_addr_ok=%0b expected none at %0t",
                         inst_addr_ok, data_addr_ok, $time);
            end else begin
                mg = gq.pop_front();
                chk("grant_owner", 32'(data_addr_ok), 32'(mg.own_data));
                chk("grant_req", 32'(req), 32'h1);
                chk("grant_addr", addr, mg.a);
                chk("grant_wr", 32'(wr), 32'(mg.w));
                chk("grant_size", 32'(size), 32'(mg.s));
                if (mg.own_data)
                    chk("grant_wdata", wdata, mg.wd);
            end
        end
        if (inst_data_ok || data_data_ok) begin
            if (dq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_data_ok: got inst_data_ok=%0b data_data_ok=%0b expected none at %0t",
                         inst_data_ok, data_data_ok, $time);
            end else begin
                md = dq.pop_front();
                chk("done_owner", 32'(data_data_ok), 32'(md.own_data));
                if (md.own_data)
                    chk("done_data_rdata", data_rdata, md.rd);
                else
                    chk("done_inst_rdata", inst_rdata, md.rd);
            end
        end
    end

    initial begin
        rst = 1'b1;
        inst_req = 1'b0;  inst_addr = 32'h0;
        data_req = 1'b1;  data_wr = 1'b0; data_size = 2'd2;
        data_addr = 32'h0; data_wdata = 32'h0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_stall_follows_req_hi", 32'(memory_stall), 32'h1);
        data_req = 1'b0;
        addr_ok = 1'b1;
        data_ok = 1'b1;
        #1;
        chk("rst_stall_follows_req_lo", 32'(memory_stall), 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wr", 32'(wr), 32'h0);
        chk("rst_size", 32'(size), 32'h2);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'h0);
        addr_ok = 1'b0;
        data_ok = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Single fetch; inst_req dropped after grant must not abort.
        inst_req  = 1'b1;
        inst_addr = 32'hbfc00000;
        gq.push_back(grant_t'{1'b0, 32'hbfc00000, 1'b0, 2'd2, 32'h0});
        dq.push_back(done_t'{1'b0, 32'h24080001});
        #1 chk("t1_req_idle", 32'(req), 32'h0);
        step();
        inst_req = 1'b0;
        addr_ok  = 1'b1;
        #1;
        chk("t1_req_addr", 32'(req), 32'h1);
        chk("t1_stall_fetch", 32'(memory_stall), 32'h0);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h24080001;
        #1 chk("t1_req_data", 32'(req), 32'h0);
        step();
        data_ok = 1'b0;
        rdata   = 32'h0;
        #1 chk("t1_req_back_idle", 32'(req), 32'h0);

        // Simultaneous requests: data first, then fetch.
        inst_req   = 1'b1;
        inst_addr  = 32'hbfc00004;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h80000010;
        data_wdata = 32'hdeadbeef;
        gq.push_back(grant_t'{1'b1, 32'h80000010, 1'b1, 2'd2, 32'hdeadbeef});
        dq.push_back(done_t'{1'b1, 32'h00000000});
        gq.push_back(grant_t'{1'b0, 32'hbfc00004, 1'b0, 2'd2, 32'h0});
        dq.push_back(done_t'{1'b0, 32'h11112222});
        #1 chk("t2_stall_idle", 32'(memory_stall), 32'h1);
        step();
        addr_ok = 1'b1;
        #1 chk("t2_stall_addr", 32'(memory_stall), 32'h1);
        step();
        addr_ok = 1'b0;
        #1 chk("t2_stall_data_wait", 32'(memory_stall), 32'h1);
        step();
        data_ok  = 1'b1;
        rdata    = 32'h0;
        data_req = 1'b0;
        data_wr  = 1'b0;
        #1 chk("t2_stall_falls", 32'(memory_stall), 32'h0);
        step();
        data_ok = 1'b0;
        #1 chk("t2_stall_idle_fetch", 32'(memory_stall), 32'h0);
        step();
        // addr_ok and data_ok together in ADDR: only addr_ok counts.
        inst_req = 1'b0;
        addr_ok  = 1'b1;
        data_ok  = 1'b1;
        rdata    = 32'hbad0bad0;
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h11112222;
        #1 chk("t2_fetch_in_data", 32'(req), 32'h0);
        step();
        data_ok = 1'b0;
        rdata   = 32'h0;

        // Spurious handshakes in IDLE.
        addr_ok = 1'b1;
        data_ok = 1'b1;
        #1 chk("t3_idle_req", 32'(req), 32'h0);
        step();
        #1;
        chk("t3_still_idle_req", 32'(req), 32'h0);
        chk("t3_still_idle_stall", 32'(memory_stall), 32'h0);
        addr_ok = 1'b0;
        data_ok = 1'b0;

        // Byte load, with a spurious addr_ok while in DATA.
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd0;
        data_addr = 32'h80000003;
        gq.push_back(grant_t'{1'b1, 32'h80000003, 1'b0, 2'd0, 32'hdeadbeef});
        dq.push_back(done_t'{1'b1, 32'h000000ab});
        #1 chk("t4_stall_req", 32'(memory_stall), 32'h1);
        step();
        addr_ok = 1'b1;
        #1;
        chk("t4_size", 32'(size), 32'h0);
        chk("t4_addr", addr, 32'h80000003);
        chk("t4_stall_addr", 32'(memory_stall), 32'h1);
        step();
        addr_ok = 1'b0;
        #1 chk("t4_stall_data", 32'(memory_stall), 32'h1);
        step();
        addr_ok = 1'b1;
        #1;
        chk("t4_spurious_req", 32'(req), 32'h0);
        chk("t4_spurious_stall", 32'(memory_stall), 32'h1);
        step();
        addr_ok  = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'h000000ab;
        data_req = 1'b0;
        #1 chk("t4_stall_falls", 32'(memory_stall), 32'h0);
        step();
        data_ok = 1'b0;
        rdata   = 32'h0;

        // Reset while in DATA abandons the transaction.
        data_req  = 1'b1;
        data_size = 2'd2;
        data_addr = 32'h80000020;
        gq.push_back(grant_t'{1'b1, 32'h80000020, 1'b0, 2'd2, 32'hdeadbeef});
        step();
        addr_ok = 1'b1;
        step();
        addr_ok  = 1'b0;
        data_req = 1'b0;
        rst      = 1'b1;
        step();
        rst     = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h77777777;
        #1;
        chk("t5_req_after_rst", 32'(req), 32'h0);
        chk("t5_stall_after_rst", 32'(memory_stall), 32'h0);
        step();
        data_ok = 1'b0;
        #1 chk("t5_idle_req", 32'(req), 32'h0);

        // Starvation: 4 data grants then 1 fetch, repeating.
        inst_req   = 1'b1;
        inst_addr  = 32'hbfc00100;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h80000040;
        data_wdata = 32'h0;
        addr_ok    = 1'b1;
        data_ok    = 1'b1;
        rdata      = 32'h5555aaaa;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                gq.push_back(grant_t'{1'b1, 32'h80000040, 1'b0, 2'd2, 32'h0});
                dq.push_back(done_t'{1'b1, 32'h5555aaaa});
            end
            gq.push_back(grant_t'{1'b0, 32'hbfc00100, 1'b0, 2'd2, 32'h0});
            dq.push_back(done_t'{1'b0, 32'h5555aaaa});
        end
        for (int c = 0; c < 30; c++)
            step();
        inst_req = 1'b0;
        data_req = 1'b0;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        step();
        step();

        chk("grants_outstanding", 32'(gq.size()), 32'h0);
        chk("completions_outstanding", 32'(dq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 The block SHALL expose the following ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- inst_req  in  1  instruction-fetch request
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  MEM-stage request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data read or write complete
- data_rdata  out  32  read data
- req  out  1  shared SRAM-like port request
- wr  out  1  shared write enable
- size  out  2  shared size
- addr  out  32  shared address
- wdata  out  32  shared write data
- addr_ok  in  1  shared address handshake
- data_ok  in  1  shared data handshake
- rdata  in  32  shared read data
- memory_stall  out  1  MEM stage waiting on memory; feeds the MEM/WB register hold
- STARVE_MAX  parameter  default 4  maximum consecutive data grants while a fetch waits

Function
REQ-002 The block SHALL multiplex one shared SRAM-like port between the fetch and data requesters, with at most one transaction outstanding at a time.
REQ-003 The FSM SHALL have three states: IDLE, ADDR (req high, waiting for addr_ok) and DATA (waiting for data_ok).
REQ-004 In IDLE, if any request is present, the block SHALL choose an owner and latch that owner's addr, wr, size and wdata, then move to ADDR on the next edge.
- Fetch transactions are latched with wr = 0 and size = 2.
REQ-005 Owner selection SHALL give data priority, unless the starvation counter equals STARVE_MAX while inst_req = 1, in which case fetch wins.
REQ-006 The starvation counter (3 bits) SHALL behave as follows on each grant:
- data grant with inst_req = 1: increment, saturating at STARVE_MAX;
- any fetch grant: clear;
- data grant with inst_req = 0: clear.
REQ-007 req SHALL be 1 only in ADDR; wr, size, addr and wdata SHALL come from the latched registers.
REQ-008 In ADDR, when addr_ok = 1, the block SHALL pulse the owner's *_addr_ok for that same cycle and move to DATA; the non-owner's addr_ok SHALL stay 0.
REQ-009 In DATA, when data_ok = 1, the block SHALL pulse the owner's *_data_ok that cycle, drive the owner's *_rdata from rdata, and return to IDLE.
REQ-010 inst_rdata and data_rdata SHALL pass rdata through combinationally; they are meaningful only while the matching data_ok is high.
REQ-011 addr_ok and data_ok SHALL be honoured only in their own state: addr_ok outside ADDR and data_ok outside DATA are ignored.
REQ-012 If addr_ok and data_ok are high in the same ADDR cycle, the block SHALL treat only addr_ok as valid.
REQ-013 memory_stall SHALL be combinational and equal to (state == IDLE & data_req) | (state != IDLE & owner == data & ~(state == DATA & data_ok)).
REQ-014 Minimum latency SHALL be 3 cycles from request to data_ok: grant, then addr_ok, then data_ok.
REQ-015 A requester that drops its request before its addr_ok SHALL NOT abort an in-flight transaction; the latched transaction completes.

Reset
REQ-016 On rst, the block SHALL set:
- state = IDLE, owner = fetch, starvation counter = 0;
- latched addr = 0, wr = 0, size = 2, wdata = 0;
- req = 0, all *_addr_ok and *_data_ok = 0.
REQ-017 rst asserted in ADDR or DATA SHALL abandon the transaction: no data_ok is forwarded afterwards, and the FSM restarts from IDLE.
REQ-018 memory_stall SHALL follow data_req during reset, because state is IDLE.

Verification
REQ-019 Single fetch: inst_req = 1, addr 0xbfc00000, addr_ok at cycle 2, data_ok at cycle 3 with rdata = 0x24080001 -> req high in cycle 2 only; inst_data_ok pulses with inst_rdata = 0x24080001.
REQ-020 Simultaneous requests: inst_req = data_req = 1, data_wr = 1, data_addr 0x80000010, data_wdata 0xdeadbeef -> data granted first (wr = 1, addr 0x80000010, wdata 0xdeadbeef); fetch granted next; memory_stall falls in the data_data_ok cycle.
REQ-021 Starvation: inst_req and data_req both held high, addr_ok and data_ok always 1 -> 4 data grants, 1 fetch grant, repeating.
REQ-022 Reset mid-operation: rst in DATA, then data_ok = 1 the following cycle -> no *_data_ok pulse; state IDLE; req = 0.
REQ-023 Spurious handshakes: data_ok = 1 in IDLE, and addr_ok = 1 in DATA -> no state change and no output pulses.
REQ-024 Byte load: data_req = 1, data_size = 0, data_addr 0x80000003 -> size = 0, addr = 0x80000003; memory_stall = 1 from request until the data_data_ok cycle.
